// File: rtl/opb_loopback_fifo.sv
// rtl/opb_loopback_fifo.sv - OPB slave with ID/CTRL/STATUS/ACNT registers and a 32-bit loopback FIFO
module opb_loopback_fifo #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0100,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [31:0] ID_VALUE        = 32'h4F50_4246
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic [31:0] OPB_ADDR,
    input  logic [31:0] OPB_DI,
    input  logic        OPB_RE,
    input  logic        OPB_WE,
    output logic [31:0] OPB_DO,
    output logic        FIFO_IRQ
);

    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;

    localparam logic [2:0] REG_ID     = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_DATA   = 3'd3;
    localparam logic [2:0] REG_ACNT   = 3'd4;

    logic          re_q, we_q;
    logic [31:2]   addr_q;
    logic [31:0]   data_q;
    logic [AW-1:0] rp, wp;
    logic [CW-1:0] count;
    logic          overflow, underflow;
    logic [15:0]   acnt;
    logic [31:0]   mem [DEPTH];

    logic        unused_addr_lsb;
    logic        fifo_empty, fifo_full;
    logic        rd_end, wr_end, q_hit, push, pop;
    logic [2:0]  q_reg;
    logic [31:0] status_word;

    assign unused_addr_lsb = ^OPB_ADDR[1:0];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));

    // End of access: strobe has dropped while its delayed copy is still high
    assign rd_end = re_q && !OPB_RE;
    assign wr_end = we_q && !OPB_WE;
    assign q_hit  = (addr_q[31:5] == BASE_ADDR[31:5]);
    assign q_reg  = addr_q[4:2];
    assign push   = wr_end && q_hit && (q_reg == REG_DATA) && !fifo_full;
    assign pop    = rd_end && q_hit && (q_reg == REG_DATA) && !fifo_empty;

    always_comb begin
        status_word         = '0;
        status_word[0]      = fifo_empty;
        status_word[1]      = fifo_full;
        status_word[2]      = overflow;
        status_word[3]      = underflow;
        status_word[8 +: CW] = count;
    end

    always_comb begin
        OPB_DO = '0;
        if (OPB_RE && !OPB_WE && (OPB_ADDR[31:5] == BASE_ADDR[31:5])) begin
            case (OPB_ADDR[4:2])
                REG_ID:     OPB_DO = ID_VALUE;
                REG_STATUS: OPB_DO = status_word;
                REG_DATA:   OPB_DO = fifo_empty ? 32'h0 : mem[rp];
                REG_ACNT:   OPB_DO = {16'h0, acnt};
                default:    OPB_DO = '0;
            endcase
        end
    end

    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) begin
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rp        <= '0;
            wp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            acnt      <= '0;
            FIFO_IRQ  <= 1'b0;
        end else begin
            // Simultaneous strobes are illegal and never arm an end of access
            re_q     <= OPB_RE && !OPB_WE;
            we_q     <= OPB_WE && !OPB_RE;
            FIFO_IRQ <= (count != '0);
            if (OPB_RE || OPB_WE)
                addr_q <= OPB_ADDR[31:2];
            if (OPB_WE)
                data_q <= OPB_DI;

            if ((rd_end || wr_end) && q_hit)
                acnt <= acnt + 16'd1;

            if (wr_end && q_hit) begin
                case (q_reg)
                    REG_CTRL: begin
                        if (data_q[0]) begin
                            rp    <= '0;
                            wp    <= '0;
                            count <= '0;
                        end
                    end
                    REG_STATUS: begin
                        if (data_q[2]) overflow  <= 1'b0;
                        if (data_q[3]) underflow <= 1'b0;
                    end
                    REG_DATA: begin
                        if (fifo_full) begin
                            overflow <= 1'b1;
                        end else begin
                            wp    <= wp + 1'b1;
                            count <= count + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (rd_end && q_hit && (q_reg == REG_DATA)) begin
                if (fifo_empty) begin
                    underflow <= 1'b1;
                end else begin
                    rp    <= rp + 1'b1;
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge OPB_CLK) begin
        if (!OPB_RST && push)
            mem[wp] <= data_q;
    end

    // pop is folded into the rp/count update above; kept as a named term for readability
    logic unused_pop;
    assign unused_pop = pop;

endmodule

// File: tb/tb_opb_loopback_fifo.sv
// tb/tb_opb_loopback_fifo.sv - scoreboard bench for opb_loopback_fifo with a queue-based reference model
module tb_opb_loopback_fifo;

    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam logic [31:0] A_ID   = BASE + 32'h00;
    localparam logic [31:0] A_CTRL = BASE + 32'h04;
    localparam logic [31:0] A_STAT = BASE + 32'h08;
    localparam logic [31:0] A_DATA = BASE + 32'h0C;
    localparam logic [31:0] A_ACNT = BASE + 32'h10;
    localparam logic [31:0] A_UNMP = BASE + 32'h14;
    localparam logic [31:0] A_MISS = 32'h0000_0200;
    localparam int          DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] OPB_ADDR = '0;
    logic [31:0] OPB_DI = '0;
    logic        OPB_RE = 1'b0;
    logic        OPB_WE = 1'b0;
    logic [31:0] OPB_DO;
    logic        FIFO_IRQ;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mq[$];
    bit          m_ov, m_un;
    logic [15:0] m_acnt;
    logic [31:0] exp_q[$];
    bit          prev_re = 1'b0;

    opb_loopback_fifo #(.BASE_ADDR(BASE), .FIFO_DEPTH_LOG2(4), .ID_VALUE(32'h4F50_4246)) dut (
        .OPB_CLK(clk), .OPB_RST(rst), .OPB_ADDR(OPB_ADDR), .OPB_DI(OPB_DI),
        .OPB_RE(OPB_RE), .OPB_WE(OPB_WE), .OPB_DO(OPB_DO), .FIFO_IRQ(FIFO_IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = (mq.size() == 0);
        s[1] = (mq.size() == DEPTH);
        s[2] = m_ov;
        s[3] = m_un;
        s[12:8] = 5'(mq.size());
        return s;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] m_read_value(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[4:0])
            5'h00: return 32'h4F50_4246;
            5'h08: return m_status();
            5'h0C: return (mq.size() == 0) ? 32'h0 : mq[0];
            5'h10: return {16'h0, m_acnt};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        mq.delete();
        m_ov = 0;
        m_un = 0;
        m_acnt = '0;
    endtask

    task automatic m_end_write(input logic [31:0] a, input logic [31:0] d);
        if (!m_hit(a)) return;
        m_acnt = m_acnt + 16'd1;
        case (a[4:0])
            5'h04: if (d[0]) mq.delete();
            5'h08: begin
                if (d[2]) m_ov = 0;
                if (d[3]) m_un = 0;
            end
            5'h0C: if (mq.size() == DEPTH) m_ov = 1; else mq.push_back(d);
            default: ;
        endcase
    endtask

    task automatic m_end_read(input logic [31:0] a);
        if (!m_hit(a)) return;
        m_acnt = m_acnt + 16'd1;
        if (a[4:0] == 5'h0C) begin
            if (mq.size() == 0) m_un = 1;
            else void'(mq.pop_front());
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int len);
        @(posedge clk); #1;
        OPB_ADDR = a; OPB_DI = d; OPB_WE = 1'b1;
        repeat (len) @(posedge clk);
        #1 OPB_WE = 1'b0;
        @(posedge clk); #1;
        m_end_write(a, d);
    endtask

    task automatic rd(input logic [31:0] a, input int len);
        @(posedge clk); #1;
        exp_q.push_back(m_read_value(a));
        OPB_ADDR = a; OPB_RE = 1'b1;
        repeat (len) @(posedge clk);
        #1 OPB_RE = 1'b0;
        @(posedge clk); #1;
        m_end_read(a);
    endtask

    task automatic check_irq(input string name);
        @(posedge clk); #1;
        check(name, {31'h0, FIFO_IRQ}, {31'h0, mq.size() != 0});
    endtask

    // Monitor: every cycle of a read frame is compared against the expected word of that frame
    always @(negedge clk) begin
        if (!rst) begin
            if (OPB_RE && OPB_WE) begin
                check("illegal_do", OPB_DO, 32'h0);
            end else if (OPB_RE) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_noexp: got %h expected no read frame", OPB_DO);
                end else begin
                    check("rd_do", OPB_DO, exp_q[0]);
                end
            end
            if (prev_re && !OPB_RE && exp_q.size() > 0)
                void'(exp_q.pop_front());
            prev_re = OPB_RE && !OPB_WE;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_irq", {31'h0, FIFO_IRQ}, 32'h0);
        check("rst_do", OPB_DO, 32'h0);

        rd(A_ID, 2);
        rd(A_STAT, 1);
        rd(A_ACNT, 3);

        for (int i = 1; i <= 3; i++) wr(A_DATA, 32'hA5A5_0000 + i, 5);
        rd(A_STAT, 2);
        check_irq("irq_3");
        for (int i = 0; i < 3; i++) rd(A_DATA, 1 + i);
        rd(A_STAT, 1);
        check_irq("irq_0");

        for (int i = 0; i < 17; i++) wr(A_DATA, 32'h1000_0000 + i * 32'h111, 1 + (i % 3));
        rd(A_STAT, 1);
        for (int i = 0; i < 16; i++) rd(A_DATA, 2);
        wr(A_STAT, 32'h4, 1);
        rd(A_STAT, 1);

        rd(A_DATA, 2);
        rd(A_STAT, 1);
        wr(A_DATA, 32'hDEAD_BEEF, 1);
        rd(A_DATA, 1);

        wr(A_DATA, 32'h0000_1111, 1);
        wr(A_DATA, 32'h0000_2222, 1);
        check_irq("irq_pre_clr");
        wr(A_CTRL, 32'h1, 2);
        check("irq_lag", {31'h0, FIFO_IRQ}, 32'h1);
        check_irq("irq_clr");
        rd(A_STAT, 1);

        wr(A_DATA, 32'h0000_3333, 1);
        @(posedge clk); #1;
        OPB_ADDR = A_DATA; OPB_DI = 32'h0BAD_0BAD; OPB_WE = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; OPB_WE = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        rd(A_ACNT, 1);
        rd(A_STAT, 1);

        @(posedge clk); #1;
        OPB_ADDR = A_DATA; OPB_DI = 32'h5555_AAAA; OPB_RE = 1'b1; OPB_WE = 1'b1;
        repeat (3) @(posedge clk);
        #1 OPB_RE = 1'b0; OPB_WE = 1'b0;
        repeat (2) @(posedge clk);
        rd(A_STAT, 1);
        rd(A_ACNT, 1);

        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2: wr(A_DATA, $urandom, int'($urandom_range(1, 4)));
                3, 4:    rd(A_DATA, int'($urandom_range(1, 4)));
                5:       rd(A_STAT, int'($urandom_range(1, 3)));
                6:       wr(($urandom_range(0, 1) != 0) ? A_STAT : A_CTRL,
                            (($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0) | ($urandom & 32'hC), 1);
                7:       rd(A_ACNT, 1);
                8:       rd(($urandom_range(0, 1) != 0) ? A_UNMP : A_MISS, 2);
                default: wr(($urandom_range(0, 1) != 0) ? A_UNMP : A_MISS, $urandom, 1);
            endcase
            if (n % 10 == 0) check_irq("irq_rand");
        end
        rd(A_STAT, 1);
        rd(A_ACNT, 1);

        repeat (3) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
